bounds_sched: RTL and testbench

Round-robin scheduler sharing one bounds-calculation pipeline among NUM_CH independent arithmetic-encoder channels. It holds each channel's working upper/lower bounds and blocks a channel while its previous symbol is still in the pipeline. It interleaves other channels into the free pipeline slots. It sits between the per-channel symbol/probability front end and the bounds-calculation pipeline, and emits each updated bound pair, tagged with its channel, to the renormalization stage.

---
 rtl/bounds_sched.sv | 199 +++++++++++++++++++
 tb/tb_bounds_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounds_sched.sv
// bounds_sched: round-robin issue of NUM_CH encoder channels into one shared bounds pipeline.
// Define BOUNDS_SCHED_BYPASS_EN to forward a returning result into a same-cycle reissue.
module bounds_sched #(
    parameter int NUM_CH = 4,
    parameter int LAT    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         sym_valid,
    output logic [NUM_CH-1:0]         sym_ready,
    input  logic [16*NUM_CH-1:0]      sym_prob_upper,
    input  logic [16*NUM_CH-1:0]      sym_prob_lower,
    input  logic [17*NUM_CH-1:0]      sym_prob_range,
    input  logic [NUM_CH-1:0]         ch_init,
    output logic [15:0]               bc_prob_upper,
    output logic [15:0]               bc_prob_lower,
    output logic [16:0]               bc_prob_range,
    output logic [15:0]               bc_work_upper,
    output logic [15:0]               bc_work_lower,
    output logic                      bc_valid_in,
    input  logic [15:0]               bc_work_upper_out,
    input  logic [15:0]               bc_work_lower_out,
    input  logic                      bc_valid_out,
    output logic                      res_valid,
    output logic [$clog2(NUM_CH)-1:0] res_ch,
    output logic [15:0]               res_work_upper,
    output logic [15:0]               res_work_lower,
    output logic                      err
);
    localparam int CW = $clog2(NUM_CH);
    localparam int DW = $clog2(LAT + 1);

    logic [15:0]       work_upper [NUM_CH];
    logic [15:0]       work_lower [NUM_CH];
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] init_pend;
    logic [CW-1:0]     rr_ptr;
    logic [LAT:0]      tag_v;
    logic [CW-1:0]     tag_ch [LAT+1];
    logic [DW-1:0]     drain_cnt;

    logic              pop_v;
    logic [CW-1:0]     pop_ch;
    logic [NUM_CH-1:0] avail;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic              gnt_any;
    logic [CW-1:0]     gnt_ch;
    logic [CW:0]       arb_sum;
    logic [CW-1:0]     arb_idx;
    logic [15:0]       sel_pu;
    logic [15:0]       sel_pl;
    logic [16:0]       sel_pr;
    logic [15:0]       sel_wu;
    logic [15:0]       sel_wl;

    assign pop_v  = tag_v[LAT];
    assign pop_ch = tag_ch[LAT];

    always_comb begin
        avail = '0;
        for (int c = 0; c < NUM_CH; c++) begin
`ifdef BOUNDS_SCHED_BYPASS_EN
            avail[c] = !busy[c] || (pop_v && pop_ch == CW'(c));
`else
            avail[c] = !busy[c];
`endif
        end
        eligible = sym_valid & avail & ~ch_init;
    end

    // first eligible channel at or after rr_ptr, wrapping
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        arb_sum = '0;
        arb_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_sum = {1'b0, rr_ptr} + (CW+1)'(i);
            if (arb_sum >= (CW+1)'(NUM_CH))
                arb_sum = arb_sum - (CW+1)'(NUM_CH);
            arb_idx = arb_sum[CW-1:0];
            if (!gnt_any && eligible[arb_idx]) begin
                gnt_any = 1'b1;
                gnt_ch  = arb_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gnt_any)
            grant[gnt_ch] = 1'b1;
    end

    assign sym_ready = rst ? '0 : grant;

    always_comb begin
        sel_pu = '0;
        sel_pl = '0;
        sel_pr = '0;
        sel_wu = '0;
        sel_wl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_ch == CW'(c)) begin
                sel_pu = sym_prob_upper[16*c +: 16];
                sel_pl = sym_prob_lower[16*c +: 16];
                sel_pr = sym_prob_range[17*c +: 17];
                sel_wu = work_upper[c];
                sel_wl = work_lower[c];
            end
        end
`ifdef BOUNDS_SCHED_BYPASS_EN
        if (pop_v && pop_ch == gnt_ch) begin
            sel_wu = init_pend[gnt_ch] ? 16'hFFFF : bc_work_upper_out;
            sel_wl = init_pend[gnt_ch] ? 16'h0000 : bc_work_lower_out;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                work_upper[c] <= 16'hFFFF;
                work_lower[c] <= 16'h0000;
            end
            for (int k = 0; k <= LAT; k++)
                tag_ch[k] <= '0;
            busy           <= '0;
            init_pend      <= '0;
            rr_ptr         <= '0;
            tag_v          <= '0;
            drain_cnt      <= DW'(LAT);
            bc_prob_upper  <= '0;
            bc_prob_lower  <= '0;
            bc_prob_range  <= '0;
            bc_work_upper  <= '0;
            bc_work_lower  <= '0;
            bc_valid_in    <= 1'b0;
            res_valid      <= 1'b0;
            res_ch         <= '0;
            res_work_upper <= '0;
            res_work_lower <= '0;
            err            <= 1'b0;
        end else begin
            tag_v     <= {tag_v[LAT-1:0], gnt_any};
            tag_ch[0] <= gnt_ch;
            for (int k = 1; k <= LAT; k++)
                tag_ch[k] <= tag_ch[k-1];

            bc_valid_in <= gnt_any;
            if (gnt_any) begin
                bc_prob_upper <= sel_pu;
                bc_prob_lower <= sel_pl;
                bc_prob_range <= sel_pr;
                bc_work_upper <= sel_wu;
                bc_work_lower <= sel_wl;
                rr_ptr <= (gnt_ch == CW'(NUM_CH - 1)) ? '0 : gnt_ch + 1'b1;
            end

            res_valid <= pop_v;
            if (pop_v) begin
                res_ch         <= pop_ch;
                res_work_upper <= bc_work_upper_out;
                res_work_lower <= bc_work_lower_out;
            end

            // results from before reset may still drain out of the pipeline
            if (drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
            if (bc_valid_out != pop_v && (pop_v || drain_cnt == '0))
                err <= 1'b1;

            for (int c = 0; c < NUM_CH; c++) begin
                if (pop_v && pop_ch == CW'(c)) begin
                    busy[c] <= 1'b0;
                    init_pend[c] <= 1'b0;
                    if (init_pend[c] || ch_init[c]) begin
                        work_upper[c] <= 16'hFFFF;
                        work_lower[c] <= 16'h0000;
                    end else begin
                        work_upper[c] <= bc_work_upper_out;
                        work_lower[c] <= bc_work_lower_out;
                    end
                end else if (ch_init[c]) begin
                    if (busy[c]) begin
                        init_pend[c] <= 1'b1;
                    end else begin
                        work_upper[c] <= 16'hFFFF;
                        work_lower[c] <= 16'h0000;
                    end
                end
                if (gnt_any && gnt_ch == CW'(c))
                    busy[c] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bounds_sched.sv
// tb_bounds_sched: directed and random stimulus for bounds_sched against a
// cycle-numbered channel model and a LAT-cycle stub pipeline.
module tb_bounds_sched;
    localparam int NUM_CH = 4;
    localparam int LAT    = 5;
    localparam int CW     = 2;
`ifdef BOUNDS_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int P = LAT + 2 - int'(BYP);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    sym_valid = '0;
    logic [3:0]    sym_ready;
    logic [63:0]   sym_prob_upper = '0;
    logic [63:0]   sym_prob_lower = '0;
    logic [67:0]   sym_prob_range = '0;
    logic [3:0]    ch_init = '0;
    logic [15:0]   bc_prob_upper, bc_prob_lower;
    logic [16:0]   bc_prob_range;
    logic [15:0]   bc_work_upper, bc_work_lower;
    logic          bc_valid_in;
    logic [15:0]   bc_work_upper_out, bc_work_lower_out;
    logic          bc_valid_out;
    logic          res_valid;
    logic [CW-1:0] res_ch;
    logic [15:0]   res_work_upper, res_work_lower;
    logic          err;
    logic          inject = 1'b0;

    bounds_sched #(.NUM_CH(NUM_CH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .sym_valid(sym_valid), .sym_ready(sym_ready),
        .sym_prob_upper(sym_prob_upper), .sym_prob_lower(sym_prob_lower),
        .sym_prob_range(sym_prob_range), .ch_init(ch_init),
        .bc_prob_upper(bc_prob_upper), .bc_prob_lower(bc_prob_lower),
        .bc_prob_range(bc_prob_range),
        .bc_work_upper(bc_work_upper), .bc_work_lower(bc_work_lower),
        .bc_valid_in(bc_valid_in),
        .bc_work_upper_out(bc_work_upper_out),
        .bc_work_lower_out(bc_work_lower_out),
        .bc_valid_out(bc_valid_out),
        .res_valid(res_valid), .res_ch(res_ch),
        .res_work_upper(res_work_upper), .res_work_lower(res_work_lower),
        .err(err)
    );

    always #5 clk = ~clk;

    // stub pipeline: not reset, so pre-reset work keeps draining
    logic        dl_v [LAT] = '{default: 1'b0};
    logic [15:0] dl_u [LAT] = '{default: 16'h0};
    logic [15:0] dl_l [LAT] = '{default: 16'h0};
    always @(posedge clk) begin
        dl_v[0] <= bc_valid_in;
        dl_u[0] <= bc_work_upper;
        dl_l[0] <= bc_work_lower;
        for (int k = 1; k < LAT; k++) begin
            dl_v[k] <= dl_v[k-1];
            dl_u[k] <= dl_u[k-1];
            dl_l[k] <= dl_l[k-1];
        end
    end
    assign bc_valid_out      = dl_v[LAT-1] | inject;
    assign bc_work_upper_out = dl_u[LAT-1] ^ 16'h00FF;
    assign bc_work_lower_out = dl_l[LAT-1] + 16'd1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: per-channel bounds, in-flight symbol and its return cycle
    logic [15:0] m_up [NUM_CH];
    logic [15:0] m_lo [NUM_CH];
    logic [15:0] m_iu [NUM_CH];
    logic [15:0] m_il [NUM_CH];
    bit          m_fl [NUM_CH];
    bit          m_pend [NUM_CH];
    int          m_pop [NUM_CH];
    int          m_rr;
    bit          m_err;

    logic [3:0]    e_rdy;
    logic          e_bcv, nx_bcv;
    logic [15:0]   e_pu, e_pl, e_wu, e_wl, nx_pu, nx_pl, nx_wu, nx_wl;
    logic [16:0]   e_pr, nx_pr;
    logic          e_rv, nx_rv;
    logic [CW-1:0] e_rc, nx_rc;
    logic [15:0]   e_ru, e_rl, nx_ru, nx_rl;
    logic          e_err, nx_err;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", n, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_up[k] = 16'hFFFF;
            m_lo[k] = 16'h0000;
            m_iu[k] = '0;
            m_il[k] = '0;
            m_fl[k] = 1'b0;
            m_pend[k] = 1'b0;
            m_pop[k] = 0;
        end
        m_rr = 0;
        m_err = 1'b0;
        nx_bcv = 1'b0;
        nx_rv = 1'b0;
        nx_err = 1'b0;
    endtask

    task automatic compare();
        chk("sym_ready", 32'(sym_ready), 32'(e_rdy));
        chk("bc_valid_in", 32'(bc_valid_in), 32'(e_bcv));
        if (e_bcv) begin
            chk("bc_prob_upper", 32'(bc_prob_upper), 32'(e_pu));
            chk("bc_prob_lower", 32'(bc_prob_lower), 32'(e_pl));
            chk("bc_prob_range", 32'(bc_prob_range), 32'(e_pr));
            chk("bc_work_upper", 32'(bc_work_upper), 32'(e_wu));
            chk("bc_work_lower", 32'(bc_work_lower), 32'(e_wl));
        end
        chk("res_valid", 32'(res_valid), 32'(e_rv));
        if (e_rv) begin
            chk("res_ch", 32'(res_ch), 32'(e_rc));
            chk("res_work_upper", 32'(res_work_upper), 32'(e_ru));
            chk("res_work_lower", 32'(res_work_lower), 32'(e_rl));
        end
        chk("err", 32'(err), 32'(e_err));
    endtask

    task automatic step(input logic r, input logic [3:0] v,
                        input logic [3:0] ini, input logic inj);
        int pop;
        int g;
        int c;
        logic [15:0] ru, rl;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        sym_valid = v;
        ch_init = ini;
        inject = inj;
        for (int k = 0; k < NUM_CH; k++) begin
            sym_prob_upper[16*k +: 16] = 16'($urandom);
            sym_prob_lower[16*k +: 16] = 16'($urandom);
            sym_prob_range[17*k +: 17] = 17'($urandom);
        end
        e_rdy = '0;
        e_bcv = nx_bcv; e_pu = nx_pu; e_pl = nx_pl; e_pr = nx_pr;
        e_wu = nx_wu; e_wl = nx_wl;
        e_rv = nx_rv; e_rc = nx_rc; e_ru = nx_ru; e_rl = nx_rl;
        e_err = nx_err;
        if (r) begin
            model_reset();
            e_bcv = 1'b0;
            e_rv = 1'b0;
            e_err = 1'b0;
        end else begin
            pop = -1;
            for (int k = 0; k < NUM_CH; k++)
                if (m_fl[k] && m_pop[k] == cyc) pop = k;
            nx_rv = 1'b0;
            if (pop >= 0) begin
                ru = m_iu[pop] ^ 16'h00FF;
                rl = m_il[pop] + 16'd1;
                nx_rv = 1'b1;
                nx_rc = CW'(pop);
                nx_ru = ru;
                nx_rl = rl;
                if (m_pend[pop] || ini[pop]) begin
                    m_up[pop] = 16'hFFFF;
                    m_lo[pop] = 16'h0000;
                end else begin
                    m_up[pop] = ru;
                    m_lo[pop] = rl;
                end
                m_pend[pop] = 1'b0;
                m_fl[pop] = 1'b0;
            end
            if (inj && pop < 0) m_err = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (ini[k]) begin
                    if (m_fl[k]) begin
                        m_pend[k] = 1'b1;
                    end else begin
                        m_up[k] = 16'hFFFF;
                        m_lo[k] = 16'h0000;
                    end
                end
            end
            g = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                c = (m_rr + i) % NUM_CH;
                if (g < 0 && v[c] && !ini[c] && !m_fl[c] && !(!BYP && c == pop))
                    g = c;
            end
            nx_bcv = 1'b0;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                nx_bcv = 1'b1;
                nx_pu = sym_prob_upper[16*g +: 16];
                nx_pl = sym_prob_lower[16*g +: 16];
                nx_pr = sym_prob_range[17*g +: 17];
                nx_wu = m_up[g];
                nx_wl = m_lo[g];
                m_iu[g] = m_up[g];
                m_il[g] = m_lo[g];
                m_fl[g] = 1'b1;
                m_pop[g] = cyc + LAT + 1;
                m_rr = (g + 1) % NUM_CH;
            end
            nx_err = m_err;
        end
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       r;
        logic [3:0] v, ini;
        model_reset();
        e_rdy = '0;

        // reset state
        step(1'b1, 4'h0, 4'h0, 1'b0);
        step(1'b1, 4'h0, 4'h0, 1'b0);
        chk("rst_ready", 32'(sym_ready), 0);
        chk("rst_bcv", 32'(bc_valid_in), 0);
        chk("rst_res", 32'(res_valid), 0);
        chk("rst_err", 32'(err), 0);

        // single symbol on channel 0
        step(1'b0, 4'b0001, 4'h0, 1'b0);
        chk("single_ready", 32'(sym_ready), 1);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        chk("single_bcv", 32'(bc_valid_in), 1);
        chk("single_wu", 32'(bc_work_upper), 'hFFFF);
        chk("single_wl", 32'(bc_work_lower), 0);
        idle(5);
        chk("single_nores", 32'(res_valid), 0);
        idle(1);
        chk("single_res", 32'(res_valid), 1);
        chk("single_ch", 32'(res_ch), 0);
        chk("single_ru", 32'(res_work_upper), 'hFF00);
        chk("single_rl", 32'(res_work_lower), 1);

        // all channels continuously valid
        step(1'b1, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k <= P + 1; k++) begin
            step(1'b0, 4'hF, 4'h0, 1'b0);
            if (k < 4) chk("rr_order", 32'(sym_ready), 1 << k);
            if (k == 4) chk("rr_gap", 32'(sym_ready), 0);
            if (k == P) chk("rr_reissue", 32'(sym_ready), 1);
        end

        // init while busy on channel 1
        idle(8);
        step(1'b0, 4'h0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 4'h0, 1'b0);
        idle(2);
        step(1'b0, 4'h0, 4'b0010, 1'b0);
        idle(4);
        chk("pend_res", 32'(res_valid), 1);
        chk("pend_ch", 32'(res_ch), 1);
        chk("pend_ru", 32'(res_work_upper), 'hFF00);
        step(1'b0, 4'b0010, 4'h0, 1'b0);
        chk("pend_ready", 32'(sym_ready), 2);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        chk("pend_wu", 32'(bc_work_upper), 'hFFFF);
        chk("pend_wl", 32'(bc_work_lower), 0);

        // reset with two symbols in flight
        idle(8);
        step(1'b0, 4'b0101, 4'h0, 1'b0);
        step(1'b0, 4'b0101, 4'h0, 1'b0);
        idle(2);
        step(1'b1, 4'h0, 4'h0, 1'b0);
        step(1'b1, 4'h0, 4'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'h0, 4'h0, 1'b0);
            chk("drain_nores", 32'(res_valid), 0);
        end
        chk("drain_err", 32'(err), 0);
        step(1'b0, 4'b0001, 4'h0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        chk("drain_wu", 32'(bc_work_upper), 'hFFFF);
        chk("drain_wl", 32'(bc_work_lower), 0);

        // spurious pipeline strobe
        idle(8);
        step(1'b0, 4'h0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        chk("spur_err", 32'(err), 1);
        idle(3);
        chk("spur_hold", 32'(err), 1);
        step(1'b0, 4'b1000, 4'h0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        chk("spur_wu", 32'(bc_work_upper), 'hFFFF);
        chk("spur_wl", 32'(bc_work_lower), 0);
        idle(7);
        step(1'b1, 4'h0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 4'h0, 1'b0);
        chk("spur_clear", 32'(err), 0);

        // channel 0 alone, continuously valid
        step(1'b0, 4'h0, 4'b0001, 1'b0);
        for (int k = 0; k <= 2 * P; k++) begin
            step(1'b0, 4'b0001, 4'h0, 1'b0);
            if (k == 0 || k == P || k == 2 * P)
                chk("solo_issue", 32'(sym_ready), 1);
            if (k == 1) chk("solo_busy", 32'(sym_ready), 0);
            if (k == P + 1) begin
                chk("solo_wu", 32'(bc_work_upper), 'hFF00);
                chk("solo_wl", 32'(bc_work_lower), 1);
            end
        end

        // random traffic with occasional init and reset
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 399) == 0);
            v = 4'($urandom) | 4'($urandom);
            ini = '0;
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 39) == 0) ini[c] = 1'b1;
            step(r, v, ini, 1'b0);
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
